fc_layer_seq: RTL and testbench
===============================

// Module: fc_layer_seq
// PURPOSE
//  Self-sequencing fully-connected layer: out[j] = sum_k in[k]*W[k][j], signed fixed point.
//  Walks the input vector itself, fetches one weight row per cycle from external sync memory,
//  MACs OUTPUT_NODES lanes in parallel, rescales/saturates, presents result on valid/ready.
//  Sits between the conv/pool stage (input_fc vector) and the next FC layer or classifier.
// PARAMETERS
//  DATA_WIDTH   16   signed operand/result width, FRAC_BITS fraction bits
//  FRAC_BITS    8    fractional bits of operands and result
//  ACC_WIDTH    40   accumulator width; must be >= 2*DATA_WIDTH+clog2(INPUT_NODES)
//  INPUT_NODES  100  input vector length
//  OUTPUT_NODES 32   output lanes (parallel MACs)
//  ADDR_WIDTH   11   weight-row address width; 2**ADDR_WIDTH >= INPUT_NODES
// PORTS
//  clk        in   1                        clock, rising edge
//  reset      in   1                        async, active-high
//  start      in   1                        run request, accepted only in IDLE
//  input_fc   in   DATA_WIDTH*INPUT_NODES   element k at [DATA_WIDTH*(INPUT_NODES-1-k) +: DATA_WIDTH]
//  w_addr     out  ADDR_WIDTH               weight row address (row k = W[k][*])
//  w_valid    out  1                        w_addr valid this cycle
//  weights    in   DATA_WIDTH*OUTPUT_NODES  row data, 1 cycle after w_addr; lane j at [DATA_WIDTH*j +: DATA_WIDTH]
//  output_fc  out  DATA_WIDTH*OUTPUT_NODES  result, lane j at [DATA_WIDTH*j +: DATA_WIDTH]
//  out_valid  out  1                        output_fc valid; held until out_ready
//  out_ready  in   1                        consumer accepts
//  busy       out  1                        high from start acceptance until handshake
//  sat_flag   out  1                        any lane saturated in this run (sticky per run)
// BEHAVIOUR
//  Reset: state IDLE; w_addr=0, w_valid=0, output_fc=0, out_valid=0, busy=0, sat_flag=0, accs=0.
//  FSM IDLE -> FETCH -> DRAIN -> RESULT -> IDLE.
//  IDLE: start=1 at edge T0 -> capture input_fc into internal reg, clear accs & sat_flag, busy=1, FETCH.
//  FETCH: INPUT_NODES cycles; cycle n drives w_addr=n, w_valid=1, registers in[n] alongside.
//   Edge ending cycle n+1: acc[j] += in[n]*weights[j] (full 2*DATA_WIDTH signed product, sign-extended).
//   After w_addr=INPUT_NODES-1 -> DRAIN (w_valid=0, w_addr holds last value).
//  DRAIN: 1 cycle, final MAC. At its end each lane: r = acc >>> FRAC_BITS (arith), saturate to
//   [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1]; registered into output_fc; sat_flag |= any clip.
//  RESULT: out_valid=1, output_fc and sat_flag stable. out_valid&out_ready at an edge -> IDLE,
//   out_valid=0, busy=0; output_fc and sat_flag keep last value until next start.
//  Latency: out_valid rises INPUT_NODES+2 cycles after the edge sampling start.
//  start while busy (incl. the handshake cycle) is ignored; no queuing.
//  input_fc changes after acceptance have no effect; weights sampled only cycle after w_valid.
//  Accumulator is ACC_WIDTH two's-complement; parameter rule guarantees no internal overflow.
//  Reset mid-run: immediate abort to reset values; no partial result emitted.
// CONFIGURATION
//  FC_RELU_EN defined: after saturation, negative lane results forced to 0 (sat_flag unaffected).
//  FC_RELU_EN undefined: signed saturated result passed unchanged.
// TESTING (bench: DATA_WIDTH=16, FRAC_BITS=8, INPUT_NODES=4, OUTPUT_NODES=2)
//  All inputs 0x0100, all weights 0x0100 -> both lanes 0x0400, sat_flag=0, out_valid 6 cycles after start.
//  Inputs 0x7FFF, weights 0x7FFF -> both lanes 0x7FFF, sat_flag=1; weights 0x8000 -> 0x8000 (no RELU).
//  Inputs 0x0100, lane0 weights 0xFF00, lane1 0x0080 -> 0xFC00/0x0200; FC_RELU_EN -> 0x0000/0x0200.
//  out_ready low 10 cycles, start pulsed -> out_valid/output_fc stable, w_valid=0, start ignored.
//  reset asserted while w_addr=2 -> all outputs 0 next cycle; fresh run then yields case-1 result.
//  input_fc changed to 0 one cycle after start -> result still from captured values (0x0400).

Source files
------------

// File: rtl/fc_layer_seq.sv
// Self-sequencing fully-connected layer: streams weight rows from a sync memory,
// runs OUTPUT_NODES signed MACs in parallel, rescales/saturates. Optional ReLU via FC_RELU_EN.
module fc_layer_seq #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ACC_WIDTH    = 40,
  parameter int INPUT_NODES  = 100,
  parameter int OUTPUT_NODES = 32,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0]  input_fc,
  output logic [ADDR_WIDTH-1:0]              w_addr,
  output logic                               w_valid,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               sat_flag
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESULT} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INPUT_NODES - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [DATA_WIDTH*INPUT_NODES-1:0]  in_cap;
  logic signed [DATA_WIDTH-1:0]       x_d;
  logic                               mac_en;
  logic signed [ACC_WIDTH-1:0]        acc     [OUTPUT_NODES];
  logic signed [ACC_WIDTH-1:0]        acc_sum [OUTPUT_NODES];
  logic signed [2*DATA_WIDTH-1:0]     prod    [OUTPUT_NODES];
  logic signed [ACC_WIDTH-1:0]        scaled  [OUTPUT_NODES];
  logic [DATA_WIDTH-1:0]              lane    [OUTPUT_NODES];
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] res_next;
  logic                               any_clip;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (w_addr == LAST_ADDR) state_next = DRAIN;
      DRAIN:   state_next = RESULT;
      RESULT:  if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Weight row for element n arrives while x_d holds in[n]; DRAIN folds in the last row.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res_next = '0;
    any_clip = 1'b0;
    for (int j = 0; j < OUTPUT_NODES; j++) begin
      prod[j]    = x_d * $signed(weights[DATA_WIDTH*j +: DATA_WIDTH]);
      acc_sum[j] = acc[j] + (mac_en ?
                   {{(ACC_WIDTH-2*DATA_WIDTH){prod[j][2*DATA_WIDTH-1]}}, prod[j]} :
                   ACC_WIDTH'(0));
      scaled[j]  = acc_sum[j] >>> FRAC_BITS;
      lane[j]    = scaled[j][DATA_WIDTH-1:0];
      if (scaled[j] > SAT_MAX) begin
        lane[j]  = SAT_MAX[DATA_WIDTH-1:0];
        any_clip = 1'b1;
      end else if (scaled[j] < SAT_MIN) begin
        lane[j]  = SAT_MIN[DATA_WIDTH-1:0];
        any_clip = 1'b1;
      end
`ifdef FC_RELU_EN
      if (lane[j][DATA_WIDTH-1]) lane[j] = '0;
`endif
      res_next[DATA_WIDTH*j +: DATA_WIDTH] = lane[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      w_addr    <= '0;
      w_valid   <= 1'b0;
      output_fc <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sat_flag  <= 1'b0;
      in_cap    <= '0;
      x_d       <= '0;
      mac_en    <= 1'b0;
      // NOTE: the accumulator bank is plain flops, so resetting it is cheap and keeps aborts clean.
      for (int j = 0; j < OUTPUT_NODES; j++) acc[j] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_next;
      mac_en <= w_valid;

      if (w_valid) begin
        x_d    <= in_cap[DATA_WIDTH*INPUT_NODES-1 -: DATA_WIDTH];
        in_cap <= in_cap << DATA_WIDTH;
      end

      if (state == IDLE && start) begin
        for (int j = 0; j < OUTPUT_NODES; j++) acc[j] <= '0;
      end else if (mac_en) begin
        for (int j = 0; j < OUTPUT_NODES; j++) acc[j] <= acc_sum[j];
      end

      case (state)
        IDLE: if (start) begin
          in_cap   <= input_fc;
          busy     <= 1'b1;
          sat_flag <= 1'b0;
          w_addr   <= '0;
          w_valid  <= 1'b1;
        end
        FETCH: begin
          if (w_addr == LAST_ADDR) w_valid <= 1'b0;
          else                     w_addr  <= w_addr + ADDR_WIDTH'(1);
        end
        DRAIN: begin
          output_fc <= res_next;
          sat_flag  <= sat_flag | any_clip;
        end
        RESULT: begin
          // Result lands at the end of DRAIN; out_valid follows one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq (4 inputs, 2 lanes); expected values honour FC_RELU_EN.
module tb_fc_layer_seq;
  localparam int DW = 16;
  localparam int IN = 4;
  localparam int ON = 2;
  localparam int AW = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DW*IN-1:0]  input_fc;
  logic [AW-1:0]     w_addr;
  logic              w_valid;
  logic [DW*ON-1:0]  weights;
  logic [DW*ON-1:0]  output_fc;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              sat_flag;

  logic [DW*ON-1:0]  wrow [IN];

  typedef struct {
    logic [DW*ON-1:0] lanes;
    logic             sat;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  fc_layer_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(8), .ACC_WIDTH(40),
    .INPUT_NODES(IN), .OUTPUT_NODES(ON), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .input_fc(input_fc),
    .w_addr(w_addr), .w_valid(w_valid), .weights(weights),
    .output_fc(output_fc), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: row appears the cycle after its address.
  always @(posedge clk) if (w_valid) weights <= wrow[w_addr[1:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", output_fc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lanes", 64'(output_fc), 64'(e.lanes));
        check("sat_flag", 64'(sat_flag), 64'(e.sat));
      end
    end
  end

  task automatic start_run(input logic [DW*IN-1:0] vec, input logic [DW*ON-1:0] row,
                           input logic [DW*ON-1:0] exp_lanes, input logic exp_sat,
                           input bit push);
    exp_t e;
    input_fc = vec;
    for (int k = 0; k < IN; k++) wrow[k] = row;
    if (push) begin
      e.lanes = exp_lanes;
      e.sat   = exp_sat;
      sb.push_back(e);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, 64'(cnt), 64'(IN + 2));
  endtask

  task automatic finish_run();
    if (!out_ready) out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_handshake", 64'({out_valid, busy}), 64'(0));
  endtask

  localparam logic [DW*IN-1:0] ONES = {IN{16'h0100}};
  localparam logic [DW*IN-1:0] MAXS = {IN{16'h7FFF}};

`ifdef FC_RELU_EN
  localparam logic [DW*ON-1:0] EXP_NEG_SAT = 32'h0000_0000;
  localparam logic [DW*ON-1:0] EXP_MIX     = 32'h0200_0000;
`else
  localparam logic [DW*ON-1:0] EXP_NEG_SAT = 32'h8000_8000;
  localparam logic [DW*ON-1:0] EXP_MIX     = 32'h0200_FC00;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; input_fc = '0; weights = '0;
    for (int k = 0; k < IN; k++) wrow[k] = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_outputs", 64'({w_valid, out_valid, busy, sat_flag}), 64'(0));
    check("rst_output_fc", 64'(output_fc), 64'(0));
    check("rst_w_addr", 64'(w_addr), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    start_run(ONES, 32'h0100_0100, 32'h0400_0400, 1'b0, 1'b1);
    check("busy_after_start", 64'(busy), 64'(1));
    wait_valid("latency_unity");
    finish_run();

    start_run(MAXS, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 1'b1, 1'b1);
    wait_valid("latency_pos_sat");
    finish_run();

    start_run(MAXS, 32'h8000_8000, EXP_NEG_SAT, 1'b1, 1'b1);
    wait_valid("latency_neg_sat");
    finish_run();

    start_run(ONES, 32'h0080_FF00, EXP_MIX, 1'b0, 1'b1);
    wait_valid("latency_mixed");
    finish_run();

    // Back-pressure: result held, start ignored while busy and on the handshake cycle.
    out_ready = 1'b0;
    start_run(ONES, 32'h0100_0100, 32'h0400_0400, 1'b0, 1'b1);
    wait_valid("latency_stall");
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(posedge clk); #1;
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_output_fc", 64'(output_fc), 64'(32'h0400_0400));
      check("stall_w_valid", 64'(w_valid), 64'(0));
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("handshake_idle", 64'({out_valid, busy}), 64'(0));
    @(posedge clk); #1;
    check("start_on_handshake_ignored", 64'({w_valid, busy}), 64'(0));
    check("output_fc_held", 64'(output_fc), 64'(32'h0400_0400));

    // Mid-run reset: abort with no result, then a fresh run.
    start_run(MAXS, 32'h7FFF_7FFF, '0, 1'b0, 1'b0);
    begin
      int cnt = 0;
      while (w_addr != AW'(2) && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("reached_w_addr_2", 64'(w_addr), 64'(2));
    end
    reset = 1'b1;
    #1;
    check("abort_outputs", 64'({w_valid, out_valid, busy, sat_flag}), 64'(0));
    check("abort_output_fc", 64'(output_fc), 64'(0));
    check("abort_w_addr", 64'(w_addr), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    start_run(ONES, 32'h0100_0100, 32'h0400_0400, 1'b0, 1'b1);
    wait_valid("latency_after_reset");
    finish_run();

    // Input bus changes after acceptance must not matter.
    start_run(ONES, 32'h0100_0100, 32'h0400_0400, 1'b0, 1'b1);
    input_fc = '0;
    wait_valid("latency_input_change");
    finish_run();

    repeat (3) @(posedge clk); #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
